// File: rtl/mempool_l0_fetch.sv
// L0 instruction fetch buffer: fully-associative lines, zero-latency hit path,
// and a single outstanding line refill over a request/response handshake.

module mempool_l0_fetch_line #(
    parameter int TagWidth  = 28,
    parameter int LineWidth = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 we_i,
    input  logic [TagWidth-1:0]  wtag_i,
    input  logic [LineWidth-1:0] wdata_i,
    input  logic [TagWidth-1:0]  ltag_i,
    output logic                 match_o,
    output logic [LineWidth-1:0] data_o
);
    logic                valid_q;
    logic [TagWidth-1:0] tag_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        valid_q <= 1'b0;
        else if (flush_i) valid_q <= 1'b0;
        else if (we_i)    valid_q <= 1'b1;
    end

    // Payload needs no reset: it is only observable through a valid match.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q  <= wtag_i;
            data_o <= wdata_i;
        end
    end

    assign match_o = valid_q && (tag_q == ltag_i);
endmodule

module mempool_l0_fetch #(
    parameter int NumLines     = 2,
    parameter int WordsPerLine = 4,
    parameter int AddrWidth    = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [AddrWidth-1:0]       inst_addr_i,
    input  logic                       inst_valid_i,
    output logic [31:0]                inst_data_o,
    output logic                       inst_ready_o,
    input  logic                       flush_i,
    output logic [AddrWidth-1:0]       refill_qaddr_o,
    output logic                       refill_qvalid_o,
    input  logic                       refill_qready_i,
    input  logic [32*WordsPerLine-1:0] refill_pdata_i,
    input  logic                       refill_pvalid_i,
    output logic                       refill_pready_o,
    output logic                       hit_o,
    output logic                       miss_o
);
    localparam int IdxWidth  = $clog2(WordsPerLine);
    localparam int TagWidth  = AddrWidth - 2 - IdxWidth;
    localparam int LineWidth = 32 * WordsPerLine;
    localparam int PtrWidth  = $clog2(NumLines);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e                        state_q;
    logic [PtrWidth-1:0]           victim_q;
    logic                          drop_q;
    logic [NumLines-1:0]           match;
    logic [NumLines-1:0]           line_we;
    logic [LineWidth-1:0]          line_data [NumLines];
    logic [TagWidth-1:0]           ltag;
    logic [TagWidth-1:0]           wtag;
    logic [IdxWidth-1:0]           widx;
    logic                          hit;
    logic                          install;
    logic [LineWidth-1:0]          sel_line;
    logic [WordsPerLine-1:0][31:0] sel_words;

    assign ltag = inst_addr_i[AddrWidth-1 -: TagWidth];
    assign widx = inst_addr_i[2 +: IdxWidth];
    assign wtag = refill_qaddr_o[AddrWidth-1 -: TagWidth];

    // A flush seen in the same cycle as the response wins over the install.
    assign install = (state_q == WAIT) && refill_pvalid_i && !drop_q && !flush_i;

    for (genvar i = 0; i < NumLines; i++) begin : g_line
        assign line_we[i] = install && (victim_q == PtrWidth'(i));

        mempool_l0_fetch_line #(
            .TagWidth (TagWidth),
            .LineWidth(LineWidth)
        ) i_line (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .flush_i(flush_i),
            .we_i   (line_we[i]),
            .wtag_i (wtag),
            .wdata_i(refill_pdata_i),
            .ltag_i (ltag),
            .match_o(match[i]),
            .data_o (line_data[i])
        );
    end

    always_comb begin
        sel_line = '0;
        for (int i = 0; i < NumLines; i++) begin
            if (match[i]) sel_line = sel_line | line_data[i];
        end
    end

    assign sel_words    = sel_line;
    assign hit          = inst_valid_i && $onehot(match);
    assign hit_o        = hit;
    assign inst_ready_o = hit;
    assign inst_data_o  = hit ? sel_words[widx] : 32'h0;
    assign miss_o       = inst_valid_i && !hit && (state_q == IDLE) && !rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            victim_q        <= '0;
            drop_q          <= 1'b0;
            refill_qaddr_o  <= '0;
            refill_qvalid_o <= 1'b0;
            refill_pready_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss_o) begin
                        refill_qaddr_o  <= {ltag, {(IdxWidth + 2){1'b0}}};
                        refill_qvalid_o <= 1'b1;
                        drop_q          <= 1'b0;
                        state_q         <= REQ;
                    end
                end
                REQ: begin
                    // The request still completes so the response stays paired.
                    if (flush_i) drop_q <= 1'b1;
                    if (refill_qready_i) begin
                        refill_qvalid_o <= 1'b0;
                        refill_pready_o <= 1'b1;
                        state_q         <= WAIT;
                    end
                end
                WAIT: begin
                    if (refill_pvalid_i) begin
                        refill_pready_o <= 1'b0;
                        drop_q          <= 1'b0;
                        state_q         <= IDLE;
                        if (install) victim_q <= victim_q + 1'b1;
                    end else if (flush_i) begin
                        drop_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mempool_l0_fetch.sv
// Bench for mempool_l0_fetch: directed scenarios plus a randomized run checked
// against a line-level model of buffer contents and the single pending refill.

module tb_mempool_l0_fetch;
    localparam int NL  = 2;
    localparam int WPL = 4;
    localparam int AW  = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [AW-1:0]     inst_addr_i;
    logic              inst_valid_i;
    logic [31:0]       inst_data_o;
    logic              inst_ready_o;
    logic              flush_i;
    logic [AW-1:0]     refill_qaddr_o;
    logic              refill_qvalid_o;
    logic              refill_qready_i;
    logic [32*WPL-1:0] refill_pdata_i;
    logic              refill_pvalid_i;
    logic              refill_pready_o;
    logic              hit_o;
    logic              miss_o;

    mempool_l0_fetch #(.NumLines(NL), .WordsPerLine(WPL), .AddrWidth(AW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .inst_addr_i    (inst_addr_i),
        .inst_valid_i   (inst_valid_i),
        .inst_data_o    (inst_data_o),
        .inst_ready_o   (inst_ready_o),
        .flush_i        (flush_i),
        .refill_qaddr_o (refill_qaddr_o),
        .refill_qvalid_o(refill_qvalid_o),
        .refill_qready_i(refill_qready_i),
        .refill_pdata_i (refill_pdata_i),
        .refill_pvalid_i(refill_pvalid_i),
        .refill_pready_o(refill_pready_o),
        .hit_o          (hit_o),
        .miss_o         (miss_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Model: which line addresses are held, their words, and the next victim slot.
    logic [AW-1:0] m_line [NL];
    bit            m_vld  [NL];
    logic [31:0]   m_data [NL][WPL];
    int            m_vic;

    function automatic logic [AW-1:0] la_of(input logic [AW-1:0] a);
        return a - (a % (4 * WPL));
    endfunction

    function automatic int widx_of(input logic [AW-1:0] a);
        return int'((a / 4) % WPL);
    endfunction

    function automatic logic [31:0] wf(input logic [AW-1:0] wa);
        logic [31:0] r;
        r = wa * 32'h9E37_79B1;
        return r ^ 32'h1234_5678;
    endfunction

    function automatic logic [32*WPL-1:0] make_line(input logic [AW-1:0] la);
        logic [32*WPL-1:0] l;
        for (int w = 0; w < WPL; w++) l[w*32 +: 32] = wf(la + AW'(4 * w));
        return l;
    endfunction

    function automatic int m_lookup(input logic [AW-1:0] a);
        for (int i = 0; i < NL; i++)
            if (m_vld[i] && m_line[i] == la_of(a)) return i;
        return -1;
    endfunction

    task automatic m_install(input logic [AW-1:0] la, input logic [32*WPL-1:0] d);
        m_line[m_vic] = la;
        m_vld[m_vic]  = 1'b1;
        for (int w = 0; w < WPL; w++) m_data[m_vic][w] = d[w*32 +: 32];
        m_vic = (m_vic + 1) % NL;
    endtask

    task automatic m_clear();
        for (int i = 0; i < NL; i++) m_vld[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Miss on addr, refill after qdelay stalled cycles, then expect a hit on cycle 3+qdelay.
    task automatic refill_line(input logic [AW-1:0] addr, input int qdelay,
                               input logic [32*WPL-1:0] line);
        int s;
        inst_addr_i = addr; inst_valid_i = 1'b1; refill_qready_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (miss_o !== 1'b1 || hit_o !== 1'b0 || inst_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL miss_start addr=%h: miss=%b hit=%b ready=%b, want 1 0 0", addr, miss_o, hit_o, inst_ready_o);
        end
        tick();
        for (int k = 0; k < qdelay; k++) begin
            @(negedge clk_i);
            checks++;
            if (refill_qvalid_o !== 1'b1 || refill_qaddr_o !== la_of(addr) || miss_o !== 1'b0) begin
                errors++;
                $display("FAIL req_hold cyc=%0d: qvalid=%b qaddr=%h miss=%b, want 1 %h 0", k, refill_qvalid_o, refill_qaddr_o, miss_o, la_of(addr));
            end
            tick();
        end
        refill_qready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (refill_qvalid_o !== 1'b1 || refill_qaddr_o !== la_of(addr) || miss_o !== 1'b0 || inst_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL req_hs: qvalid=%b qaddr=%h miss=%b ready=%b, want 1 %h 0 0", refill_qvalid_o, refill_qaddr_o, miss_o, inst_ready_o, la_of(addr));
        end
        tick();
        refill_qready_i = 1'b0; refill_pvalid_i = 1'b1; refill_pdata_i = line;
        @(negedge clk_i);
        checks++;
        if (refill_pready_o !== 1'b1 || refill_qvalid_o !== 1'b0 || inst_ready_o !== 1'b0 || miss_o !== 1'b0) begin
            errors++;
            $display("FAIL wait_resp: pready=%b qvalid=%b ready=%b miss=%b, want 1 0 0 0", refill_pready_o, refill_qvalid_o, inst_ready_o, miss_o);
        end
        tick();
        refill_pvalid_i = 1'b0;
        m_install(la_of(addr), line);
        s = m_lookup(addr);
        @(negedge clk_i);
        checks++;
        if (s < 0 || inst_ready_o !== 1'b1 || hit_o !== 1'b1 || inst_data_o !== m_data[s < 0 ? 0 : s][widx_of(addr)]) begin
            errors++;
            $display("FAIL refill_hit addr=%h: ready=%b hit=%b data=%h, want 1 1 %h", addr, inst_ready_o, hit_o, inst_data_o, m_data[s < 0 ? 0 : s][widx_of(addr)]);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        inst_valid_i = 1'b0; inst_addr_i = '0; flush_i = 1'b0;
        refill_qready_i = 1'b0; refill_pvalid_i = 1'b0; refill_pdata_i = '0;
        m_clear(); m_vic = 0;
        @(negedge clk_i);
        checks++;
        if ({inst_ready_o, hit_o, miss_o, refill_qvalid_o, refill_pready_o} !== 5'b0 ||
            inst_data_o !== 32'h0 || refill_qaddr_o !== '0) begin
            errors++;
            $display("FAIL reset_outs: rdy/hit/miss/qv/pr=%b data=%h qaddr=%h, want all 0",
                     {inst_ready_o, hit_o, miss_o, refill_qvalid_o, refill_pready_o}, inst_data_o, refill_qaddr_o);
        end
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_cold_miss();
        logic [32*WPL-1:0] l;
        l = {32'hDDDD000D, 32'hCCCC000C, 32'hBBBB000B, 32'hAAAA0001};
        refill_line(32'h1000, 0, l);
        checks++;
        if (inst_data_o !== 32'hAAAA0001) begin
            errors++;
            $display("FAIL cold_word0: data=%h, want aaaa0001", inst_data_o);
        end
        tick();
    endtask

    task automatic test_seq_hits();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'hBBBB000B; exp_w[1] = 32'hCCCC000C; exp_w[2] = 32'hDDDD000D;
        for (int k = 0; k < 3; k++) begin
            inst_addr_i = 32'h1004 + 32'(4 * k); inst_valid_i = 1'b1;
            @(negedge clk_i);
            checks++;
            if (inst_ready_o !== 1'b1 || hit_o !== 1'b1 || miss_o !== 1'b0 ||
                refill_qvalid_o !== 1'b0 || inst_data_o !== exp_w[k]) begin
                errors++;
                $display("FAIL seq_hit %h: ready=%b hit=%b miss=%b qv=%b data=%h, want 1 1 0 0 %h",
                         inst_addr_i, inst_ready_o, hit_o, miss_o, refill_qvalid_o, inst_data_o, exp_w[k]);
            end
            tick();
        end
    endtask

    task automatic test_replacement();
        refill_line(32'h2000, 0, make_line(32'h2000));
        tick();
        refill_line(32'h3008, 0, make_line(32'h3000));
        tick();
        inst_addr_i = 32'h2004; inst_valid_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (hit_o !== 1'b1 || miss_o !== 1'b0 || inst_data_o !== wf(32'h2004)) begin
            errors++;
            $display("FAIL wrap_keep 2004: hit=%b miss=%b data=%h, want 1 0 %h", hit_o, miss_o, inst_data_o, wf(32'h2004));
        end
        tick();
        refill_line(32'h1000, 0, make_line(32'h1000));
        tick();
    endtask

    task automatic test_backpressure();
        refill_line(32'h400C, 5, make_line(32'h4000));
        tick();
    endtask

    task automatic test_flush_wait();
        inst_addr_i = 32'h5004; inst_valid_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (miss_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_miss1: miss=%b, want 1", miss_o);
        end
        tick();
        refill_qready_i = 1'b1;
        tick();
        refill_qready_i = 1'b0; flush_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (refill_pready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_wait_pready: pready=%b, want 1", refill_pready_o);
        end
        tick();
        flush_i = 1'b0; m_clear();
        refill_pvalid_i = 1'b1; refill_pdata_i = make_line(32'h5000);
        tick();
        refill_pvalid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (miss_o !== 1'b1 || hit_o !== 1'b0 || inst_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop: miss=%b hit=%b ready=%b, want 1 0 0", miss_o, hit_o, inst_ready_o);
        end
        tick();
        refill_qready_i = 1'b1;
        tick();
        refill_qready_i = 1'b0; refill_pvalid_i = 1'b1; refill_pdata_i = make_line(32'h5000);
        tick();
        refill_pvalid_i = 1'b0;
        m_install(32'h5000, make_line(32'h5000));
        inst_addr_i = 32'h4000;
        @(negedge clk_i);
        checks++;
        if (miss_o !== 1'b1 || hit_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_old_gone: miss=%b hit=%b, want 1 0", miss_o, hit_o);
        end
        inst_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        m_clear(); m_vic = 0;
        tick();
        inst_addr_i = 32'h6000; inst_valid_i = 1'b1;
        tick();
        refill_qready_i = 1'b1;
        tick();
        refill_qready_i = 1'b0; inst_valid_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({inst_ready_o, hit_o, miss_o, refill_qvalid_o, refill_pready_o} !== 5'b0 ||
            inst_data_o !== 32'h0 || refill_qaddr_o !== '0) begin
            errors++;
            $display("FAIL reset_mid: rdy/hit/miss/qv/pr=%b data=%h qaddr=%h, want all 0",
                     {inst_ready_o, hit_o, miss_o, refill_qvalid_o, refill_pready_o}, inst_data_o, refill_qaddr_o);
        end
        tick();
        rst_i = 1'b0;
        refill_pvalid_i = 1'b1; refill_pdata_i = make_line(32'h6000);
        @(negedge clk_i);
        checks++;
        if (refill_pready_o !== 1'b0) begin
            errors++;
            $display("FAIL stale_resp_pready: pready=%b, want 0", refill_pready_o);
        end
        tick();
        refill_pvalid_i = 1'b0;
        inst_addr_i = 32'h6000; inst_valid_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (miss_o !== 1'b1 || hit_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_refetch: miss=%b hit=%b, want 1 0", miss_o, hit_o);
        end
        inst_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [AW-1:0] pool [6];
        bit            pending, accepted, drop, resp_out;
        logic [AW-1:0] pend_la;
        int            resp_dly, s;
        bit            e_hit, e_miss, e_qv, e_pr;
        logic [31:0]   e_data;
        for (int k = 0; k < 6; k++) pool[k] = 32'h0001_0000 + 32'(32'h40 * k);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        m_clear(); m_vic = 0;
        pending = 0; accepted = 0; drop = 0; resp_out = 0; resp_dly = 0; pend_la = '0;
        for (int c = 0; c < 3000; c++) begin
            inst_valid_i    = ($urandom_range(0, 3) != 0);
            inst_addr_i     = pool[$urandom_range(0, 5)] + 32'(4 * $urandom_range(0, WPL - 1));
            flush_i         = ($urandom_range(0, 24) == 0);
            refill_qready_i = $urandom_range(0, 1) == 1;
            refill_pvalid_i = resp_out && (resp_dly == 0);
            refill_pdata_i  = refill_pvalid_i ? make_line(pend_la) : {WPL{$urandom()}};
            s      = m_lookup(inst_addr_i);
            e_hit  = inst_valid_i && (s >= 0);
            e_data = e_hit ? m_data[s][widx_of(inst_addr_i)] : 32'h0;
            e_miss = inst_valid_i && !e_hit && !pending;
            e_qv   = pending && !accepted;
            e_pr   = pending && accepted;
            @(negedge clk_i);
            checks++;
            if (inst_ready_o !== e_hit || hit_o !== e_hit || inst_data_o !== e_data ||
                miss_o !== e_miss || refill_qvalid_o !== e_qv || refill_pready_o !== e_pr ||
                (e_qv && refill_qaddr_o !== pend_la)) begin
                errors++;
                $display("FAIL rand cyc=%0d addr=%h: rdy/hit/miss/qv/pr=%b%b%b%b%b data=%h qaddr=%h, want %b%b%b%b%b %h %h",
                         c, inst_addr_i, inst_ready_o, hit_o, miss_o, refill_qvalid_o, refill_pready_o,
                         inst_data_o, refill_qaddr_o, e_hit, e_hit, e_miss, e_qv, e_pr, e_data, pend_la);
            end
            if (resp_out) begin
                if (refill_pvalid_i) resp_out = 0;
                else if (resp_dly > 0) resp_dly--;
            end
            if (e_qv && refill_qready_i) begin
                accepted = 1; resp_out = 1; resp_dly = $urandom_range(0, 3);
            end
            if (e_pr && refill_pvalid_i) begin
                if (!drop && !flush_i) m_install(pend_la, make_line(pend_la));
                pending = 0; drop = 0;
            end else if (pending && flush_i) begin
                drop = 1;
            end
            if (flush_i) m_clear();
            if (e_miss) begin
                pending = 1; accepted = 0; drop = 0; pend_la = la_of(inst_addr_i);
            end
            tick();
        end
        inst_valid_i = 1'b0; flush_i = 1'b0; refill_pvalid_i = 1'b0; refill_qready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_seq_hits();
        test_replacement();
        test_backpressure();
        test_flush_wait();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mempool_l0_fetch.md
MEMPOOL_L0_FETCH -- requirements
Module: mempool_l0_fetch

Interface
REQ-001 SHALL have parameter NumLines, default 2, meaning number of fully-associative buffer lines (power of two, >=2).
REQ-002 SHALL have parameter WordsPerLine, default 4, meaning 32-bit instruction words per line (power of two, >=2).
REQ-003 SHALL have parameter AddrWidth, default 32, meaning fetch address width.
REQ-004 SHALL have port clk_i  input  1  clock; reset rst_i, asynchronous, active-high; clock clk_i.
REQ-005 SHALL have port rst_i  input  1  asynchronous active-high reset.
REQ-006 SHALL have port inst_addr_i  input  AddrWidth  core fetch address.
REQ-007 SHALL have port inst_valid_i  input  1  core fetch request.
REQ-008 SHALL have port inst_data_o  output  32  fetched instruction word.
REQ-009 SHALL have port inst_ready_o  output  1  fetch served this cycle.
REQ-010 SHALL have port flush_i  input  1  invalidate all lines (fence.i).
REQ-011 SHALL have port refill_qaddr_o  output  AddrWidth  line-aligned refill address.
REQ-012 SHALL have port refill_qvalid_o / refill_qready_i  output/input  1/1  refill request handshake.
REQ-013 SHALL have port refill_pdata_i  input  32*WordsPerLine  refill line, word 0 in bits [31:0].
REQ-014 SHALL have port refill_pvalid_i / refill_pready_o  input/output  1/1  refill response handshake.
REQ-015 SHALL have port hit_o, miss_o  output  1 each  single-cycle event strobes.

Function
REQ-016 SHALL split address: offset = 2 bits (byte), word index = log2(WordsPerLine) bits, tag = remaining upper bits.
REQ-017 SHALL compare tag against all valid lines combinationally; hit = inst_valid_i and exactly one matching valid line.
REQ-018 SHALL on hit drive inst_ready_o=1 and inst_data_o=selected word in the same cycle (zero-latency hit), hit_o=1.
REQ-019 SHALL drive inst_ready_o=0 whenever no hit; inst_data_o is don't-care then but SHALL be driven to 0.
REQ-020 SHALL implement FSM IDLE -> REQ -> WAIT -> IDLE.
REQ-021 IDLE: on inst_valid_i and miss, latch line-aligned address, pulse miss_o for one cycle, go REQ next cycle.
REQ-022 REQ: assert refill_qvalid_o with stable refill_qaddr_o until refill_qready_i; on handshake go WAIT.
REQ-023 WAIT: refill_pready_o=1; on refill_pvalid_i write line into victim slot, set its valid bit, store tag, advance victim pointer (round-robin, wraps NumLines-1 -> 0), go IDLE.
REQ-024 refill_pready_o SHALL be 1 only in WAIT; refill_qvalid_o only in REQ.
REQ-025 Only one refill SHALL be outstanding; miss lookups in REQ/WAIT SHALL not start a new refill.
REQ-026 Hits on other lines SHALL still be served while in REQ/WAIT.
REQ-027 Core changing inst_addr_i during a pending miss SHALL not abort the refill; the line is still installed, and the new address is looked up from IDLE.
REQ-028 Minimum miss latency: request in cycle 0, refill_qvalid_o cycle 1, with qready=1 and response in cycle 2 -> inst_ready_o in cycle 3.
REQ-029 flush_i SHALL clear all valid bits at the next edge; flush has priority over a same-cycle line write.
REQ-030 flush_i in REQ SHALL complete the request handshake; flush_i in REQ or WAIT SHALL set a drop flag so the returning line is discarded (not installed, pointer unchanged), flag cleared on return to IDLE.
REQ-031 hit_o/miss_o SHALL never be asserted in the same cycle.

Reset
REQ-032 On rst_i: all valid bits 0, victim pointer 0, FSM IDLE, drop flag 0, refill_qvalid_o=0, refill_pready_o=0, inst_ready_o=0, inst_data_o=0, hit_o=0, miss_o=0, refill_qaddr_o=0.
REQ-033 rst_i asserted mid-refill SHALL abandon the transaction; an in-flight response arriving after reset release in IDLE SHALL be ignored.

Verification
REQ-034 Cold miss: fetch 0x1000 after reset, qready=1, pdata={0x..D,0x..C,0x..B,0xAAAA0001} in cycle 2 -> qaddr=0x1000 in cycle 1, inst_data_o=0xAAAA0001, ready in cycle 3, miss_o once.
REQ-035 Sequential hits: after REQ-034, fetch 0x1004,0x1008,0x100C -> ready each cycle, hit_o each cycle, no refill.
REQ-036 Replacement wrap: NumLines=2, miss 0x1000, 0x2000, 0x3000 -> 0x3000 evicts 0x1000 slot; refetch 0x1000 misses, 0x2000 hits.
REQ-037 Backpressure: refill_qready_i low 5 cycles -> qvalid_o and qaddr stable 5 cycles, single handshake.
REQ-038 Flush in WAIT: flush_i during WAIT, then response -> line not installed, refetch same address misses again.
REQ-039 Reset mid-refill: rst_i in WAIT -> all outputs at reset values, next fetch misses.
